// File: rtl/snake_input_ctrl.sv
// rtl/snake_input_ctrl.sv - key/switch conditioner and game-step generator for the snake core
//
// Synchronises and debounces the three active-low direction keys and four
// point switches, produces a one-cycle game-step strobe on clk, and commits
// key requests into a 2-bit direction that never reverses in a single step.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   button_n[2:0] raw keys, active-low: [2] KEY2, [1] KEY1, [0] KEY0
//   sw[3:0]      raw point switches, active-high
//   tick_o       one-cycle game-step strobe
//   dir_o[1:0]   committed direction: 00 forward, 01 KEY0, 10 KEY2, 11 KEY1
//   key_press_o  one-cycle pulse per debounced key press
//   sw_db_o      debounced switch levels
//   sw_rise_o    one-cycle pulse on debounced switch 0->1
//   reverse_o    one-cycle pulse when a requested reversal is rejected
module snake_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int TICK_DIV        = 67108864,
  parameter int CNT_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] button_n,
  input  logic [3:0] sw,
  output logic       tick_o,
  output logic [1:0] dir_o,
  output logic [2:0] key_press_o,
  output logic [3:0] sw_db_o,
  output logic [3:0] sw_rise_o,
  output logic       reverse_o
);

  localparam int NB = 7;
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
  // Bits [2:0] are keys (idle high), bits [6:3] are switches (idle low).
  localparam logic [NB-1:0] IDLE = 7'b000_0111;

  logic [NB-1:0]    s1_q, s1_d, s2_q, s2_d;
  logic [NB-1:0]    stable_q, stable_d;
  logic [CNT_W-1:0] db_cnt_q [NB];
  logic [CNT_W-1:0] db_cnt_d [NB];
  logic [2:0]       key_press_q, key_press_d;
  logic [3:0]       sw_rise_q, sw_rise_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  logic [1:0]       req_q, req_d;
  logic             req_valid_q, req_valid_d;
  logic [1:0]       dir_q, dir_d;
  logic             reverse_q, reverse_d;

  always_comb begin
    s1_d     = {sw, button_n};
    s2_d     = s1_q;
    stable_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      db_cnt_d[i] = '0;
      // Any sample matching the stable value restarts the count.
      if (s2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          stable_d[i] = ~stable_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 1'b1;
        end
      end
    end

    key_press_d = stable_q[2:0] & ~stable_d[2:0];
    sw_rise_d   = ~stable_q[6:3] & stable_d[6:3];

    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // A press in the tick cycle itself is kept for the following tick.
    req_d       = req_q;
    req_valid_d = req_valid_q;
    if (|key_press_q) begin
      req_valid_d = 1'b1;
      if (key_press_q[2])      req_d = 2'b10;
      else if (key_press_q[1]) req_d = 2'b11;
      else                     req_d = 2'b01;
    end else if (tick) begin
      req_valid_d = 1'b0;
    end

    // Opposite directions differ only in the upper code bit.
    dir_d     = dir_q;
    reverse_d = 1'b0;
    if (tick && req_valid_q) begin
      if ((dir_q ^ req_q) == 2'b10) reverse_d = 1'b1;
      else                          dir_d     = req_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= IDLE;
      s2_q        <= IDLE;
      stable_q    <= IDLE;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= '0;
      key_press_q <= '0;
      sw_rise_q   <= '0;
      tick_cnt_q  <= '0;
      req_q       <= '0;
      req_valid_q <= 1'b0;
      dir_q       <= 2'b11;
      reverse_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      stable_q    <= stable_d;
      for (int i = 0; i < NB; i++) db_cnt_q[i] <= db_cnt_d[i];
      key_press_q <= key_press_d;
      sw_rise_q   <= sw_rise_d;
      tick_cnt_q  <= tick_cnt_d;
      req_q       <= req_d;
      req_valid_q <= req_valid_d;
      dir_q       <= dir_d;
      reverse_q   <= reverse_d;
    end
  end

  assign tick_o      = tick;
  assign dir_o       = dir_q;
  assign key_press_o = key_press_q;
  assign sw_db_o     = stable_q[6:3];
  assign sw_rise_o   = sw_rise_q;
  assign reverse_o   = reverse_q;

endmodule

// File: tb/tb_snake_input_ctrl.sv
// tb/tb_snake_input_ctrl.sv - scoreboard bench for snake_input_ctrl
module tb_snake_input_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] button_n = 3'b111;
  logic [3:0] sw = 4'b0000;
  logic       tick_o;
  logic [1:0] dir_o;
  logic [2:0] key_press_o;
  logic [3:0] sw_db_o;
  logic [3:0] sw_rise_o;
  logic       reverse_o;

  snake_input_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .TICK_DIV       (16),
    .CNT_W          (26)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .button_n   (button_n),
    .sw         (sw),
    .tick_o     (tick_o),
    .dir_o      (dir_o),
    .key_press_o(key_press_o),
    .sw_db_o    (sw_db_o),
    .sw_rise_o  (sw_rise_o),
    .reverse_o  (reverse_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ticks    = 0;
  logic [1:0] prev_dir  = 2'b11;
  logic       prev_tick = 1'b0;

  // Event codes: 16+i key press, 32+i switch rise, 48 reverse, 64+d dir change.
  typedef struct {
    int code;
    int lo;
    int hi;
  } ev_t;
  ev_t sb[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic expect_ev(input int code, input int lo, input int hi);
    ev_t e;
    e.code = code;
    e.lo   = lo;
    e.hi   = hi;
    sb.push_back(e);
  endtask

  task automatic see_ev(input int code);
    ev_t e;
    if (sb.size() == 0) begin
      check("ev_unexpected", code, 0);
    end else begin
      e = sb.pop_front();
      check("ev_code", code, e.code);
      check("ev_window", int'(cyc >= e.lo && cyc <= e.hi), 1);
    end
  endtask

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_dir  <= dir_o;
      prev_tick <= 1'b0;
    end else begin
      if (tick_o) begin
        check("tick_phase", cyc % 16, 15);
        ticks <= ticks + 1;
      end
      for (int i = 2; i >= 0; i--) if (key_press_o[i]) see_ev(16 + i);
      for (int i = 3; i >= 0; i--) if (sw_rise_o[i]) see_ev(32 + i);
      if (reverse_o) see_ev(48);
      if (dir_o != prev_dir) begin
        see_ev(64 + int'(dir_o));
        check("dir_after_tick", int'(prev_tick), 1);
      end
      prev_dir  <= dir_o;
      prev_tick <= tick_o;
    end
  end

  task automatic check_reset_state();
    check("rst_dir", int'(dir_o), 3);
    check("rst_tick", int'(tick_o), 0);
    check("rst_pulses", int'({key_press_o, sw_rise_o, reverse_o}), 0);
    check("rst_sw_db", int'(sw_db_o), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset_state();
    rst = 1'b0;

    // Idle: ticks at 15, 31, 47 and no events.
    at(50);
    check("tick_count", ticks, 3);
    check("idle_dir", int'(dir_o), 3);

    // Bouncing KEY1, final fall at 60; same-direction request changes nothing.
    at(52); button_n[1] = 1'b0;
    at(54); button_n[1] = 1'b1;
    at(56); button_n[1] = 1'b0;
    at(58); button_n[1] = 1'b1;
    at(60); button_n[1] = 1'b0;
    expect_ev(16 + 1, 66, 67);
    at(70); button_n[1] = 1'b1;

    // KEY0 against 11 is a reversal: rejected at tick 95.
    at(82); button_n[0] = 1'b0;
    expect_ev(16 + 0, 88, 89);
    expect_ev(48, 96, 96);
    at(90); button_n[0] = 1'b1;

    // KEY2 accepted at tick 111.
    at(100); button_n[2] = 1'b0;
    expect_ev(16 + 2, 106, 107);
    expect_ev(64 + 2, 112, 112);
    at(108); button_n[2] = 1'b1;

    // KEY0 from 10 accepted at tick 127.
    at(116); button_n[0] = 1'b0;
    expect_ev(16 + 0, 122, 123);
    expect_ev(64 + 1, 128, 128);
    at(124); button_n[0] = 1'b1;

    // KEY2 and KEY1 together: KEY2 wins, 01 -> 10 at tick 143.
    at(132); button_n[2:1] = 2'b00;
    expect_ev(16 + 2, 138, 139);
    expect_ev(16 + 1, 138, 139);
    expect_ev(64 + 2, 144, 144);
    at(140); button_n[2:1] = 2'b11;

    // KEY1 then KEY0 before tick 159: last press wins, 10 -> 01.
    at(148); button_n[1] = 1'b0;
    expect_ev(16 + 1, 154, 155);
    at(150); button_n[0] = 1'b0;
    expect_ev(16 + 0, 156, 157);
    expect_ev(64 + 1, 160, 160);
    at(156); button_n[1] = 1'b1;
    at(158); button_n[0] = 1'b1;

    // KEY2 press landing on tick 175 is committed at tick 191 instead.
    at(169); button_n[2] = 1'b0;
    expect_ev(16 + 2, 175, 175);
    expect_ev(64 + 2, 192, 192);
    at(175);
    check("press_on_tick", int'({tick_o, key_press_o[2]}), 3);
    at(176);
    check("dir_held_after_tick", int'(dir_o), 1);
    at(180); button_n[2] = 1'b1;

    // Switch 2 rise, then fall without a pulse.
    at(200); sw[2] = 1'b1;
    expect_ev(32 + 2, 206, 207);
    at(210);
    check("sw_db_level", int'(sw_db_o), 4);
    at(212); sw[2] = 1'b0;
    at(222);
    check("sw_db_fall", int'(sw_db_o), 0);

    // Rise again, reset 3 cycles later: edge in flight is abandoned.
    at(224); sw[2] = 1'b1;
    at(227); rst = 1'b1; sw[2] = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check_reset_state();
    rst = 1'b0;
    at(25);
    check("post_rst_sw_db", int'(sw_db_o), 0);
    check("post_rst_dir", int'(dir_o), 3);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
